// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// ALU operand selection and load-use hazard detection for the RV32I core.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [3:0]        id_alu_op,
  input  logic              id_alu_src_a,
  input  logic              id_alu_src_b,
  input  logic              id_reg_we,
  input  logic              id_mem_re,
  input  logic              id_mem_we,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_fwd_we,
  input  logic [REG_AW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0]   mem_fwd_data,
  input  logic              wb_fwd_we,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]   wb_fwd_data,
  output logic              load_use_hazard,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_we,
  output logic              ex_mem_re,
  output logic              ex_mem_we
);

  localparam logic [3:0] ALU_ADD = 4'b0000;

  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;
  logic [XLEN-1:0]   ex_imm;
  logic [REG_AW-1:0] ex_rs1_addr;
  logic [REG_AW-1:0] ex_rs2_addr;
  logic              ex_src_a;
  logic              ex_src_b;
  logic              reg_we_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic              load_bubble;
  logic              rs1_hit;
  logic              rs2_hit;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // A load in EX cannot forward its data until MEM/WB, so a dependent
  // instruction in ID must wait one cycle while EX takes a bubble.
  assign rs1_hit = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use_hazard = ex_valid && mem_re_q && (ex_rd_addr != '0) &&
                           id_valid && (rs1_hit || rs2_hit);

  assign load_bubble = flush || (!stall && (load_use_hazard || !id_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      alu_op      <= ALU_ADD;
      ex_src_a    <= 1'b0;
      ex_src_b    <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else if (load_bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      alu_op      <= ALU_ADD;
      ex_src_a    <= 1'b0;
      ex_src_b    <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else if (!stall) begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1_addr <= id_rs1_addr;
      ex_rs2_addr <= id_rs2_addr;
      ex_rd_addr  <= id_rd_addr;
      alu_op      <= id_alu_op;
      ex_src_a    <= id_alu_src_a;
      ex_src_b    <= id_alu_src_b;
      reg_we_q    <= id_reg_we;
      mem_re_q    <= id_mem_re;
      mem_we_q    <= id_mem_we;
    end
  end

  // EX/MEM is the younger writer, so it wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_rs1 = ex_rs1_data;
    if (ex_rs1_addr != '0 && mem_fwd_we && mem_fwd_rd == ex_rs1_addr)
      fwd_rs1 = mem_fwd_data;
    else if (ex_rs1_addr != '0 && wb_fwd_we && wb_fwd_rd == ex_rs1_addr)
      fwd_rs1 = wb_fwd_data;
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    if (ex_rs2_addr != '0 && mem_fwd_we && mem_fwd_rd == ex_rs2_addr)
      fwd_rs2 = mem_fwd_data;
    else if (ex_rs2_addr != '0 && wb_fwd_we && wb_fwd_rd == ex_rs2_addr)
      fwd_rs2 = wb_fwd_data;
  end

  assign alu_a         = ex_src_a ? ex_pc : fwd_rs1;
  assign alu_b         = ex_src_b ? ex_imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_reg_we     = ex_valid && reg_we_q;
  assign ex_mem_re     = ex_valid && mem_re_q;
  assign ex_mem_we     = ex_valid && mem_we_q;

endmodule
